alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand and result width; legal values are 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter SHW, default $clog2(XLEN), the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, marking the operation presented this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit, high when the block can accept an operation.
REQ-007 The block SHALL have port op, input, 5 bits, the operation select.
REQ-008 The block SHALL have ports a and b, input, XLEN bits each, the operands.
REQ-009 The block SHALL have port out_valid, output, 1 bit, marking a result held for the consumer.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the consumer accept.
REQ-011 The block SHALL have port result, output, XLEN bits, the registered result.
REQ-012 The block SHALL have port zero, output, 1 bit, equal to (result == 0) and registered with result.
REQ-013 The block SHALL have port illegal, output, 1 bit, marking that the op was unsupported; it is registered with result.

Function
REQ-014 Base ops, op[4]=0, SHALL be:
- 0_0010 ADD
- 0_0110 SUB
- 0_0000 AND
- 0_0001 OR
- 0_1100 XOR
- 0_0111 SLT, signed
- 0_1111 SLTU
- 0_1101 SLL
- 0_1001 SRL
- 0_1011 SRA, sign-filling
- 0_1010 PASSB
REQ-015 Shifts SHALL use only b[SHW-1:0] as the shift amount.
REQ-016 M ops, op[4]=1, SHALL be:
- 1_0000 MUL, low XLEN bits
- 1_0001 MULH, signed x signed
- 1_0010 MULHSU
- 1_0011 MULHU
- 1_0100 DIV
- 1_0101 DIVU
- 1_0110 REM
- 1_0111 REMU
REQ-017 Any other op code SHALL produce result 0 and illegal=1, with base-op latency.
REQ-018 A transfer SHALL occur on in_valid & in_ready; op, a and b are captured only on that cycle.
REQ-019 The FSM SHALL have three states:
- IDLE: in_ready=1.
- BUSY: in_ready=0, iterating.
- DONE: out_valid=1, and in_ready=out_ready.
REQ-020 For a base or illegal op accepted in IDLE, the FSM SHALL go IDLE->DONE; out_valid rises the following cycle (latency 1).
REQ-021 For an M op, the FSM SHALL go IDLE->BUSY and run exactly XLEN iterations (shift-add multiply, restoring divide on magnitudes), then go to DONE; out_valid rises XLEN+1 cycles after acceptance.
REQ-022 In DONE, result, zero and illegal SHALL stay stable until out_valid & out_ready.
REQ-023 In DONE with out_ready=1 and in_valid=1, the block SHALL retire the current result and accept the new operation in the same cycle (back-to-back with no bubble for base ops).
REQ-024 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE.
REQ-025 Divide by zero: DIV/DIVU SHALL return all-ones, REM/REMU SHALL return a, and illegal=0.
REQ-026 Signed overflow (most-negative / -1): DIV SHALL return a and REM SHALL return 0.
REQ-027 Signed results SHALL be formed by negating the magnitude result: the quotient sign is a^b, the remainder sign is that of a.
REQ-028 An iteration counter of SHW+1 bits SHALL load XLEN and terminate at 0, with no wrap-around.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL enter IDLE and set in_ready=1, out_valid=0, result=0, zero=1, illegal=0 and the counter to 0.
REQ-030 A reset during BUSY or DONE SHALL abandon the operation with no result emitted; reset has priority over all handshakes.

Configuration
REQ-031 With macro ALU_SEQ_MDU_EN defined, the multiply/divide datapath and the BUSY state SHALL be present and REQ-016 through REQ-028 apply.
REQ-032 Without ALU_SEQ_MDU_EN, all op[4]=1 codes SHALL be treated as illegal per REQ-017, no BUSY state or iteration datapath is synthesised, and every op has latency 1.

Verification
REQ-033 Directed scenarios (XLEN=32, ALU_SEQ_MDU_EN defined unless stated):
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> result=0, zero=1, out_valid exactly 1 cycle after acceptance.
- SRA a=0x80000000, b=0x00000024 -> result=0xF8000000 (shift 4, upper b bits ignored); SRL same inputs -> 0x08000000.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU a=7, b=0 -> 0xFFFFFFFF; REMU a=7, b=0 -> 7; each after 33 cycles, in_ready=0 throughout BUSY.
- MULH a=0xFFFFFFFE, b=3 -> 0xFFFFFFFF; MULHU same -> 0x00000002; MUL same -> 0xFFFFFFFA; hold out_ready=0 for 5 cycles -> result stable, no new acceptance.
- Stream of 4 ADDs with in_valid=out_ready=1 -> 4 results on 4 consecutive cycles; assert rst_n=0 mid-DIV -> out_valid=0, in_ready=1 on the next cycle and no stale result.
- Without ALU_SEQ_MDU_EN: op=1_0000 -> result=0, illegal=1, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Define ALU_SEQ_MDU_EN
// to add the iterative multiply/divide unit (shift-add multiply, restoring divide).
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    // state | meaning
    // IDLE  | waiting for an operation, in_ready=1
    // BUSY  | multiply/divide iterating, in_ready=0
    // DONE  | result held, out_valid=1, in_ready follows out_ready
`ifdef ALU_SEQ_MDU_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t          state;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            base_ill;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];

    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (op)
            5'b00010: base_res = a + b;
            5'b00110: base_res = a - b;
            5'b00000: base_res = a & b;
            5'b00001: base_res = a | b;
            5'b01100: base_res = a ^ b;
            5'b00111: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            5'b01111: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            5'b01101: base_res = a << shamt;
            5'b01001: base_res = a >> shamt;
            5'b01011: base_res = $signed(a) >>> shamt;
            5'b01010: base_res = b;
            default:  base_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MDU_EN
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);

    logic [SHW:0]      cnt;
    logic [XLEN-1:0]   hi, lo, mcand;
    logic [2:0]        mop;
    logic              neg, div0;
    logic              sa, sb, a_neg, b_neg, neg_init;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, mdu_res;
    logic [2*XLEN-1:0] prod_s;

    // Signedness and final sign are fixed at acceptance; the loop works on magnitudes.
    always_comb begin
        sa    = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        sb    = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        a_neg = sa && a[XLEN-1];
        b_neg = sb && b[XLEN-1];
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;
        if (op[2] && op[1])
            neg_init = a_neg;
        else if (op[2])
            neg_init = (a_neg ^ b_neg) && (b != '0);
        else
            neg_init = a_neg ^ b_neg;
    end

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        rem_sh = {hi, lo[XLEN-1]};
        diff   = rem_sh - {1'b0, mcand};
        if (mop[2]) begin
            if (!diff[XLEN]) begin
                nxt_hi = diff[XLEN-1:0];
                nxt_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                nxt_hi = rem_sh[XLEN-1:0];
                nxt_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[XLEN:1];
            nxt_lo = {sum[0], lo[XLEN-1:1]};
        end
        prod_s = neg ? -{nxt_hi, nxt_lo} : {nxt_hi, nxt_lo};
        case (mop)
            3'b000:                 mdu_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: mdu_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         mdu_res = div0 ? '1 : (neg ? -nxt_lo : nxt_lo);
            default:                mdu_res = neg ? -nxt_hi : nxt_hi;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
`ifdef ALU_SEQ_MDU_EN
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            mop       <= '0;
            neg       <= 1'b0;
            div0      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef ALU_SEQ_MDU_EN
                        if (op[4]) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            cnt       <= CNT_INIT;
                            hi        <= '0;
                            lo        <= op[2] ? mag_a : mag_b;
                            mcand     <= op[2] ? mag_b : mag_a;
                            mop       <= op[2:0];
                            neg       <= neg_init;
                            div0      <= (b == '0);
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= base_res;
                            zero      <= (base_res == '0);
                            illegal   <= base_ill;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MDU_EN
                BUSY: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt - (SHW+1)'(1);
                    // The last iteration writes its result directly.
                    if (cnt == (SHW+1)'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= mdu_res;
                        zero      <= (mdu_res == '0);
                        illegal   <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: table-driven vectors through a scoreboard plus
// hand-written latency, hold, streaming and reset sequences.
module tb_alu_seq;
    localparam int XLEN = 32;
    localparam logic [4:0] OP_ADD = 5'b00010, OP_SUB = 5'b00110, OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR = 5'b00001, OP_XOR = 5'b01100, OP_SLT = 5'b00111;
    localparam logic [4:0] OP_SLTU = 5'b01111, OP_SLL = 5'b01101, OP_SRL = 5'b01001;
    localparam logic [4:0] OP_SRA = 5'b01011, OP_PASSB = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM = 5'b10110, OP_REMU = 5'b10111;

    logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [4:0] op;
    logic [XLEN-1:0] a, b, result;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        string       nm;
    } vec_t;
    typedef struct {
        logic [31:0] res;
        logic        ill;
        string       nm;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb[$];
    exp_t  mon_e;
    int    ret_cyc[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    cnt_bad;
    int    n;
    logic [4:0]  hold_op;
    logic [31:0] hold_exp;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            ret_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_result_count", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_result"}, 64'(result), 64'(mon_e.res));
                chk({mon_e.nm, "_illegal"}, 64'(illegal), 64'(mon_e.ill));
                chk({mon_e.nm, "_zero"}, 64'(zero), 64'(mon_e.res == 32'd0));
            end
        end
    end

    function automatic void add_vec(input logic [4:0] o, input logic [31:0] x,
                                    input logic [31:0] y, input logic [31:0] r,
                                    input logic il, input string nm);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.ill = il; v.nm = nm;
        vecs.push_back(v);
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ei, input string nm);
        int k;
        exp_t e;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        for (k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        chk({nm, "_accept"}, 64'(in_ready), 64'd1);
        e.res = er; e.ill = ei; e.nm = nm;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        add_vec(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "add_wrap");
        add_vec(OP_SUB,   32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, "sub");
        add_vec(OP_AND,   32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, "and");
        add_vec(OP_OR,    32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0, "or");
        add_vec(OP_XOR,   32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0, "xor");
        add_vec(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, "slt");
        add_vec(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, "sltu");
        add_vec(OP_SLL,   32'h00000001, 32'h00000021, 32'h00000002, 1'b0, "sll");
        add_vec(OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, "sra");
        add_vec(OP_SRL,   32'h80000000, 32'h00000024, 32'h08000000, 1'b0, "srl");
        add_vec(OP_PASSB, 32'h11111111, 32'h12345678, 32'h12345678, 1'b0, "passb");
        add_vec(5'b00011, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, "ill_00011");
        add_vec(5'b01110, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, "ill_01110");
`ifdef ALU_SEQ_MDU_EN
        add_vec(OP_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, "mulh");
        add_vec(OP_MULHU,  32'hFFFFFFFE, 32'h00000003, 32'h00000002, 1'b0, "mulhu");
        add_vec(OP_MUL,    32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b0, "mul");
        add_vec(OP_MULHSU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, "mulhsu");
        add_vec(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "div_ovf");
        add_vec(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, "rem_ovf");
        add_vec(OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0, "divu_by0");
        add_vec(OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007, 1'b0, "remu_by0");
        add_vec(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, "div_neg");
        add_vec(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, "rem_neg");
        add_vec(OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b0, "div_by0");
        add_vec(OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0, "rem_by0");
        add_vec(OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, "divu");
        add_vec(OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 1'b0, "remu");
        hold_op = OP_MULH;  hold_exp = 32'hFFFFFFFF;
`else
        add_vec(OP_MUL, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, "mul_off");
        add_vec(OP_DIV, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, "div_off");
        hold_op = OP_PASSB; hold_exp = 32'h00000003;
`endif

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_illegal", 64'(illegal), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Base-op latency: valid in the cycle after acceptance, then back to IDLE.
        send(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, "add_lat");
        @(negedge clk);
        chk("add_lat1_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("add_idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, vecs[i].nm);
            wait_drain();
        end

`ifdef ALU_SEQ_MDU_EN
        send(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, "div_lat");
        cnt_bad = 0;
        for (int k = 1; k <= XLEN; k++) begin
            @(negedge clk);
            if (out_valid || in_ready) cnt_bad++;
        end
        chk("div_busy_cycles", 64'(cnt_bad), 64'd0);
        @(negedge clk);
        chk("div_lat33_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
`else
        send(OP_MUL, 32'h5, 32'h3, 32'h0, 1'b1, "mul_off_lat");
        @(negedge clk);
        chk("mul_off_lat1_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
`endif
        wait_drain();

        // Hold the result with out_ready low while another op waits.
        out_ready = 1'b0;
        send(hold_op, 32'hFFFFFFFE, 32'h3, hold_exp, 1'b0, "hold");
        for (n = 0; n < 60 && !out_valid; n++) @(negedge clk);
        chk("hold_valid", 64'(out_valid), 64'd1);
        op = OP_ADD; a = 32'h1; b = 32'h1; in_valid = 1'b1;
        cnt_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || result !== hold_exp || in_ready) cnt_bad++;
        end
        chk("hold_stable", 64'(cnt_bad), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(OP_ADD, 32'h1, 32'h1, 32'h2, 1'b0, "after_hold");
        wait_drain();

        ret_cyc.delete();
        for (int k = 0; k < 4; k++)
            send(OP_ADD, 32'(k), 32'd10, 32'(k + 10), 1'b0, "stream");
        wait_drain();
        chk("stream_count", 64'(ret_cyc.size()), 64'd4);
        if (ret_cyc.size() >= 4)
            chk("stream_span", 64'(ret_cyc[3] - ret_cyc[0]), 64'd3);

`ifdef ALU_SEQ_MDU_EN
        send(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, "div_rst");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_busy_valid", 64'(out_valid), 64'd0);
        chk("rst_busy_ready", 64'(in_ready), 64'd1);
        cnt_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) cnt_bad++;
        end
        chk("rst_busy_no_stale", 64'(cnt_bad), 64'd0);
        @(posedge clk); #1;
`endif

        out_ready = 1'b0;
        send(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, "done_rst");
        @(negedge clk);
        chk("done_rst_valid_before", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("done_rst_valid", 64'(out_valid), 64'd0);
        chk("done_rst_result", 64'(result), 64'd0);
        chk("done_rst_zero", 64'(zero), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        send(OP_SUB, 32'd9, 32'd4, 32'd5, 1'b0, "post_rst_sub");
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
